// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

    // Sequencer phases: waiting for a request, driving the memory port, waiting out read latency.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Which requester owns the current (or most recent) transaction.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // RV32I word-width code; fetches always use it.
    localparam logic [2:0] FUNCT3_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and one-transaction-at-a-time sequencer that shares the
// single-ported unified memory between instruction fetch and load/store.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_funct3,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic [31:0] read_address,
    input  logic [31:0] read_data,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        write_mem,
    output logic [2:0]  funct3
);

    // The WAIT counter starts at READ_LATENCY-1 so that rvalid lands READ_LATENCY
    // cycles after the issue cycle; two bits cover the supported range 1..4.
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    owner_t      lastOwner_q, lastOwner_d;
    owner_t      owner_q, owner_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  count_q, count_d;

    logic        ifGnt;
    logic        dGnt;
    logic        rvalidHit;

    // Grants are only given in IDLE; on a tie the requester not served last wins.
    always_comb begin
        ifGnt = 1'b0;
        dGnt  = 1'b0;
        if (state_q == IDLE) begin
            if (if_req && d_req) begin
                if (lastOwner_q == FETCH) begin
                    dGnt = 1'b1;
                end else begin
                    ifGnt = 1'b1;
                end
            end else if (if_req) begin
                ifGnt = 1'b1;
            end else if (d_req) begin
                dGnt = 1'b1;
            end
        end
    end

    // Next-state logic: capture the granted request, then issue, then wait for read data.
    always_comb begin
        state_d     = state_q;
        lastOwner_d = lastOwner_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (ifGnt) begin
                    state_d     = ISSUE;
                    owner_d     = FETCH;
                    lastOwner_d = FETCH;
                    addr_d      = if_addr;
                    we_d        = 1'b0;
                    funct3_d    = FUNCT3_WORD;
                end else if (dGnt) begin
                    state_d     = ISSUE;
                    owner_d     = DATA;
                    lastOwner_d = DATA;
                    addr_d      = d_addr;
                    wdata_d     = d_wdata;
                    we_d        = d_we;
                    funct3_d    = d_funct3;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    count_d = LAT_LOAD;
                end
            end
            WAIT: begin
                if (count_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-request registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastOwner_q <= FETCH;
            owner_q     <= FETCH;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            funct3_q    <= FUNCT3_WORD;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            lastOwner_q <= lastOwner_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            count_q     <= count_d;
        end
    end

    // Read data is valid in the last WAIT cycle; only the owner sees the strobe.
    assign rvalidHit = (state_q == WAIT) && (count_q == 2'd0) && !we_q;

    assign if_gnt    = ifGnt;
    assign d_gnt     = dGnt;
    assign if_rvalid = rvalidHit && (owner_q == FETCH);
    assign d_rvalid  = rvalidHit && (owner_q == DATA);
    assign if_rdata  = read_data;
    assign d_rdata   = read_data;

    // The captured registers only change on entry to ISSUE, so the memory
    // port naturally holds its last values in every other phase.
    assign read_address  = addr_q;
    assign write_address = addr_q;
    assign write_data    = wdata_q;
    assign funct3        = funct3_q;
    assign write_mem     = (state_q == ISSUE) && we_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and sequencer for the single-ported unified memory in the multicycle core. It shares the memory between the instruction-fetch requester (read-only) and the load/store requester (read or write, with `funct3` width control). It registers each granted request and drives the memory port for exactly one transaction at a time. It waits out the memory read latency and returns read data to the granted requester with a one-cycle valid strobe.

## Interface
- `READ_LATENCY`, default 1: cycles from the issue cycle (address on `read_address`) to valid `read_data`. Legal range 1..4.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request. Held high with `if_addr` stable until `if_gnt`.
- `if_addr`  in  32  fetch byte address.
- `if_gnt`  out  1  fetch request accepted this cycle.
- `if_rvalid`  out  1  one-cycle strobe: `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request. Held high with payload stable until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data.
- `d_funct3`  in  3  RV32I load/store width code, passed to memory.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  one-cycle strobe: `d_rdata` valid. Loads only.
- `d_rdata`  out  32  load data, as returned by memory.
- `read_address`  out  32  memory read address.
- `read_data`  in  32  memory read data.
- `write_address`  out  32  memory write address.
- `write_data`  out  32  memory write data.
- `write_mem`  out  1  memory write enable.
- `funct3`  out  3  memory access width code.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE on any grant.
  - ISSUE → WAIT for a read.
  - ISSUE → IDLE for a write.
  - WAIT → IDLE when the latency counter expires.
- IDLE grant rules:
  - `if_gnt`/`d_gnt` are combinational from the requests and the round-robin pointer. At most one is high, and only in IDLE.
  - On grant, the arbiter captures the address, write data, we and `funct3` into internal registers, plus the owner ID.
  - Fetch always uses `funct3` = 3'b010 (word) and we = 0.
- Round-robin arbitration:
  - A single requester is granted immediately.
  - When both request, the one not granted last wins.
  - `last_owner` resets to FETCH, so the first tie after reset goes to DATA.
- ISSUE:
  - `read_address` and `write_address` both carry the captured address. `write_data` and `funct3` carry the captured values.
  - `write_mem` = captured we, high for exactly this one cycle.
- WAIT:
  - The counter loads `READ_LATENCY`-1 on entry and counts down.
  - At zero, the arbiter asserts the owner's rvalid for one cycle, with rdata = `read_data` (combinational pass-through), then returns to IDLE.
- Stores never produce `d_rvalid`.
- The non-owner's rvalid stays 0 at all times.
- Requests arriving outside IDLE wait; no gnt is given outside IDLE.

## Timing
- Grant in cycle T.
- Issue in cycle T+1.
- Read data and rvalid in cycle T+1+`READ_LATENCY`.
- Next grant is possible at T+2+`READ_LATENCY` for reads, and at T+2 for writes.
- Memory outputs hold their last values outside ISSUE; `write_mem` is 0 outside ISSUE.
- Reset values:
  - State IDLE, `last_owner` FETCH.
  - All addresses and data outputs 0; `funct3` 3'b010; `write_mem` 0.
  - All gnt/rvalid outputs 0; counter 0.
- Asserting `rst_n` mid-transaction takes effect immediately and asynchronously:
  - `write_mem` drops at once.
  - The pending read is dropped; no rvalid is ever issued for it.
  - Requesters must re-request after reset.

## Structure
- Package `mem_arb_pkg` holds:
  - `state_t` enum {IDLE, ISSUE, WAIT}.
  - `owner_t` enum {FETCH, DATA}.
  - `FUNCT3_WORD` = 3'b010.
- No sub-module. Arbitration, FSM and counter live in one module of roughly 150 lines.

## Test plan
- Fetch alone, L=1:
  - Stimulus: `if_req` with `if_addr`=0x10 in cycle 0; memory returns 0x00500093.
  - Required: `if_gnt`@0; `read_address`=0x10, `funct3`=010 @1; `if_rvalid`@2 with `if_rdata`=0x00500093.
- Store:
  - Stimulus: `d_req`, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_funct3`=000.
  - Required: `d_gnt`@0; `write_mem`=1 for exactly cycle 1 with `write_address`=0x100, `write_data`=0xDEADBEEF, `funct3`=000; `d_rvalid` never asserted.
- Simultaneous requests after reset, held continuously:
  - Required: grant order DATA, FETCH, DATA, FETCH; each read completes before the next grant.
- `READ_LATENCY`=3, load at 0x20:
  - Required: `d_rvalid` exactly at cycle 4; no grant in cycles 1–4 even with `if_req` high.
- Reset asserted in cycle 1 of a store:
  - Required: `write_mem` falls immediately; state IDLE; no rvalid afterwards.
- Fetch issued at T=0 with `d_req` rising at cycle 1:
  - Required: `d_gnt` held 0 until cycle 3 (L=1), granted in cycle 3.
